// File: rtl/boot_pkg.sv
// Shared boot sequencer types: FSM states, boot ROM fallback identity and default source constants.
package boot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2,
        RUN   = 2'd3
    } boot_state_e;

    localparam logic [31:0] BROM_ADDR = 32'h6000_0000;
    localparam logic [31:0] BROM_TAG  = 32'h4252_4F4D;  // "BROM"
    localparam logic [31:0] ICCM_ADDR = 32'h1000_0000;
    localparam logic [31:0] ICCM_TAG  = 32'h4943_434D;  // "ICCM"
    localparam logic [31:0] QSPI_ADDR = 32'h8000_0008;
    localparam logic [31:0] QSPI_TAG  = 32'h5153_5049;  // "QSPI"

    function automatic int sel_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/boot_seq_mngr_if.sv
// Control/status bundle between the platform boot controller (master) and boot_seq_mngr (slave).
interface boot_seq_mngr_if #(
    parameter int SEL_W = 1
);
    logic             management_i;
    logic             load_start_i;
    logic             prog_done_i;
    logic [SEL_W-1:0] boot_sel_i;
    logic [31:0]      boot_addr_o;
    logic [31:0]      boot_reg_val_o;
    logic             core_rst_no;
    logic             boot_locked_o;
    logic             timeout_o;

    modport master (
        output management_i, load_start_i, prog_done_i, boot_sel_i,
        input  boot_addr_o, boot_reg_val_o, core_rst_no, boot_locked_o, timeout_o
    );

    modport slave (
        input  management_i, load_start_i, prog_done_i, boot_sel_i,
        output boot_addr_o, boot_reg_val_o, core_rst_no, boot_locked_o, timeout_o
    );
endinterface

// File: rtl/boot_timeout_cnt.sv
// Load watchdog: counts enabled cycles from a clear, flags the last allowed cycle, saturates instead of wrapping.
// expired is combinational on the count so the FSM can act in the same cycle; no flow control.
module boot_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic por_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CAP   = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != CAP) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/boot_seq_mngr.sv
// Boot sequencer: waits for the loader (or its timeout), latches the boot address/tag, then releases core reset.
// prog_done in LOAD cycle N gives new address and core_rst_no=1 at N+2; no backpressure, pulses outside LOAD/RUN rules are dropped.
module boot_seq_mngr
    import boot_pkg::*;
#(
    parameter int                       NUM_SRC     = 2,
    parameter int                       TIMEOUT_CYC = 1024,
    parameter logic [NUM_SRC-1:0][31:0] SRC_ADDR    = {QSPI_ADDR, ICCM_ADDR},
    parameter logic [NUM_SRC-1:0][31:0] SRC_TAG     = {QSPI_TAG, ICCM_TAG}
) (
    input  logic           clk_i,
    input  logic           por_ni,
    boot_seq_mngr_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_SRC);

    boot_state_e      state_q;
    logic [SEL_W-1:0] sel_q;
    logic             fallback_q;
    logic [31:0]      addr_q;
    logic [31:0]      tag_q;
    logic             core_rst_n_q;
    logic             locked_q;
    logic             timeout_q;
    logic             expired;
    logic [31:0]      apply_addr;
    logic [31:0]      apply_tag;

    // Counter is held at zero outside LOAD, so every LOAD entry starts a fresh window.
    boot_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .por_ni (por_ni),
        .clear  (state_q != LOAD),
        .enable (state_q == LOAD),
        .expired(expired)
    );

    // Unmatched select values (>= NUM_SRC) fall through to the boot ROM.
    always_comb begin
        apply_addr = BROM_ADDR;
        apply_tag  = BROM_TAG;
        if (!fallback_q) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    apply_addr = SRC_ADDR[i];
                    apply_tag  = SRC_TAG[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge por_ni) begin
        if (!por_ni) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            fallback_q   <= 1'b0;
            addr_q       <= BROM_ADDR;
            tag_q        <= BROM_TAG;
            core_rst_n_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_start_i) begin
                        state_q   <= LOAD;
                        timeout_q <= 1'b0;
                    end
                end
                LOAD: begin
                    // A completion on the last allowed cycle beats the timeout.
                    if (bus.prog_done_i) begin
                        sel_q      <= bus.boot_sel_i;
                        fallback_q <= 1'b0;
                        state_q    <= APPLY;
                    end else if (expired) begin
                        fallback_q <= 1'b1;
                        timeout_q  <= 1'b1;
                        state_q    <= APPLY;
                    end
                end
                APPLY: begin
                    addr_q       <= apply_addr;
                    tag_q        <= apply_tag;
                    core_rst_n_q <= 1'b1;
                    locked_q     <= 1'b1;
                    state_q      <= RUN;
                end
                RUN: begin
                    if (bus.load_start_i && bus.management_i) begin
                        core_rst_n_q <= 1'b0;
                        locked_q     <= 1'b0;
                        timeout_q    <= 1'b0;
                        state_q      <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.boot_addr_o    = addr_q;
    assign bus.boot_reg_val_o = tag_q;
    assign bus.core_rst_no    = core_rst_n_q;
    assign bus.boot_locked_o  = locked_q;
    assign bus.timeout_o      = timeout_q;

endmodule

// File: doc/boot_seq_mngr.md
BOOT_SEQ_MNGR -- requirements
Module: boot_seq_mngr

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of loadable boot sources, range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: LOAD-state cycles allowed before falling back to BROM, range 1..2^20.
REQ-003 SHALL have parameter SRC_ADDR[NUM_SRC] x 32, default {0x1000_0000 (ICCM), 0x8000_0008 (QSPI)}: boot address per source.
REQ-004 SHALL have parameter SRC_TAG[NUM_SRC] x 32, default {0x4943_434D "ICCM", 0x5153_5049 "QSPI"}: ASCII tag per source.
REQ-005 SHALL have port clk_i, input, 1: main clock.
REQ-006 SHALL have port por_ni, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port management_i, input, 1: management override; permits re-load while running.
REQ-008 SHALL have port load_start_i, input, 1: single-cycle pulse, program loading begins.
REQ-009 SHALL have port prog_done_i, input, 1: program loading into ICCM/QSPI complete, level.
REQ-010 SHALL have port boot_sel_i, input, SEL_W = max(1, $clog2(NUM_SRC)): boot source index.
REQ-011 SHALL have port boot_addr_o, output, 32: registered boot address.
REQ-012 SHALL have port boot_reg_val_o, output, 32: registered ASCII tag of the active source.
REQ-013 SHALL have port core_rst_no, output, 1: core reset release, active-low.
REQ-014 SHALL have port boot_locked_o, output, 1: boot address is frozen.
REQ-015 SHALL have port timeout_o, output, 1: sticky flag, last load ended by timeout.

Function
REQ-016 SHALL implement states IDLE, LOAD, APPLY, RUN.
REQ-017 IDLE: outputs hold BROM values (0x6000_0000 / 0x4252_4F4D); core_rst_no=0; load_start_i -> LOAD, counter cleared, timeout_o cleared.
REQ-018 LOAD: counter increments each cycle; core_rst_no=0; boot_locked_o=0.
REQ-019 LOAD: prog_done_i=1 -> APPLY, boot_sel_i registered in the same cycle.
REQ-020 LOAD: counter == TIMEOUT_CYC-1 with prog_done_i=0 -> APPLY with BROM selected; timeout_o set.
REQ-021 LOAD: if prog_done_i and the timeout occur in the same cycle, prog_done_i SHALL win; timeout_o stays 0.
REQ-022 APPLY: lasts one cycle; loads boot_addr_o/boot_reg_val_o from SRC_ADDR/SRC_TAG[sel], or BROM on fallback; next state RUN.
REQ-023 APPLY: a registered sel >= NUM_SRC SHALL select BROM and SHALL NOT set timeout_o.
REQ-024 RUN: core_rst_no=1 and boot_locked_o=1, both from the first RUN cycle; boot_addr_o and boot_reg_val_o frozen.
REQ-025 RUN: load_start_i with management_i=1 -> LOAD; core_rst_no drops to 0 next cycle; address outputs keep their prior value until APPLY.
REQ-026 RUN: load_start_i with management_i=0 SHALL be ignored.
REQ-027 boot_sel_i and prog_done_i changes outside LOAD SHALL have no effect.
REQ-028 Latency: prog_done_i high in LOAD cycle N -> new boot_addr_o at N+2, core_rst_no=1 at N+2.
REQ-029 Counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide and SHALL never wrap.

Reset
REQ-030 On por_ni=0, asynchronously: state=IDLE, boot_addr_o=0x6000_0000, boot_reg_val_o=0x4252_4F4D, core_rst_no=0, boot_locked_o=0, timeout_o=0, counter=0.
REQ-031 Reset asserted mid-LOAD or mid-RUN SHALL abort to the reset values with no residual state.

Structure
REQ-032 Package boot_pkg SHALL hold the state enum, the BROM_ADDR/BROM_TAG constants and the default ICCM/QSPI address and tag constants.
REQ-033 The timeout counter SHALL be a sub-module boot_timeout_cnt (clear, enable, expired); the FSM and output registers stay in boot_seq_mngr.

Verification
REQ-034 Reset -> outputs 0x6000_0000 / 0x4252_4F4D, core_rst_no=0, boot_locked_o=0.
REQ-035 load_start_i, boot_sel_i=1, prog_done_i after 10 cycles -> boot_addr_o=0x8000_0008, tag 0x5153_5049, core_rst_no=1 two cycles later.
REQ-036 TIMEOUT_CYC=16, load_start_i, no prog_done_i -> after 16 LOAD cycles boot_addr_o=0x6000_0000, timeout_o=1, core_rst_no=1.
REQ-037 In RUN: load_start_i with management_i=0 -> no change; with management_i=1 -> core_rst_no=0, then reload with sel=0 -> 0x1000_0000 / 0x4943_434D.
REQ-038 prog_done_i on the final timeout cycle -> source address applied, timeout_o=0; boot_sel_i=3 with NUM_SRC=3 -> BROM selected, timeout_o=0.
REQ-039 por_ni pulsed low mid-LOAD -> immediate reset values; a subsequent load sequence completes normally.
